// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB register-port responder.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ID,
        ID_ACK,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } sccb_state_e;

    localparam logic [7:0] SCCB_DEV_ID = 8'h42;

endpackage

// File: rtl/sccb_line_sync.sv
// Synchronizer for one SCCB line plus a flop holding the previous synchronized sample.
// Flops preset to 1 so an idle (pulled-up) bus produces no edges out of reset.
module sccb_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic sync_o,
    output logic prev_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    // next values: shift the raw line in, remember the last synchronized sample
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], line_i};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // synchronizer and previous-sample registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign prev_o = prev_q;

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder emulating an OmniVision camera register port.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | bus free, waiting for START
// ID       | receiving device address byte
// ID_ACK   | driving ACK for the device address
// ADDR     | receiving register address byte
// ADDR_ACK | driving ACK for the register address
// DATA     | receiving a write data byte
// DATA_ACK | driving ACK for a write data byte
// RD_DATA  | shifting a read byte out on SIOD
// RD_ACK   | SIOD released, sampling the master's ACK/NACK
// IGNORE   | not addressed or master NACKed; wait for START/STOP
module sccb_slave
    import sccb_pkg::*;
#(
    parameter logic [7:0] DEV_ID      = SCCB_DEV_ID,
    parameter int         SYNC_STAGES = 2,
    parameter bit         AUTO_INC    = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       sioc_i,
    input  logic       siod_i,
    output logic       siod_oe_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_wdata_o,
    output logic       reg_we_o,
    input  logic [7:0] reg_rdata_i,
    output logic       busy_o
);

    logic c, cp, d, dp;
    logic start_ev, stop_ev, rise_ev, fall_ev;

    sccb_state_e state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        byte_done_q, byte_done_d;
    logic [7:0]  shift_q, shift_d;
    logic [6:0]  rd_sh_q, rd_sh_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        inc_q, inc_d;
    logic        oe_q, oe_d;
    logic        busy_q, busy_d;
    logic        rw_q, rw_d;

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sioc (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (sioc_i),
        .sync_o (c),
        .prev_o (cp)
    );

    sccb_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_siod (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .line_i (siod_i),
        .sync_o (d),
        .prev_o (dp)
    );

    assign start_ev = c & cp & dp & ~d;
    assign stop_ev  = c & cp & ~dp & d;
    assign rise_ev  = c & ~cp;
    assign fall_ev  = ~c & cp;

    // next-state and datapath: START/STOP win, data sampled on RISE, drive changed on FALL
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        byte_done_d = byte_done_q;
        shift_d     = shift_q;
        rd_sh_d     = rd_sh_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = 1'b0;
        inc_d       = 1'b0;
        oe_d        = oe_q;
        busy_d      = busy_q;
        rw_d        = rw_q;

        // write-side auto-increment lands the clock after the strobe
        if (inc_q) begin
            addr_d = addr_q + 8'd1;
        end

        if (start_ev) begin
            state_d     = ID;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            busy_d      = 1'b1;
            oe_d        = 1'b0;
        end else if (stop_ev) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            busy_d      = 1'b0;
            oe_d        = 1'b0;
        end else if (rise_ev) begin
            case (state_q)
                ID, ADDR, DATA, RD_DATA: begin
                    shift_d   = {shift_q[6:0], d};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_done_d = 1'b1;
                    end
                end
                RD_ACK: begin
                    if (d) begin
                        state_d = IGNORE;
                    end else if (AUTO_INC) begin
                        addr_d = addr_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end else if (fall_ev) begin
            case (state_q)
                ID: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        rw_d        = shift_q[0];
                        if (shift_q[7:1] == DEV_ID[7:1]) begin
                            state_d = ID_ACK;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = IGNORE;
                        end
                    end
                end
                ID_ACK: begin
                    if (rw_q) begin
                        state_d = RD_DATA;
                        rd_sh_d = reg_rdata_i[6:0];
                        oe_d    = ~reg_rdata_i[7];
                    end else begin
                        state_d = ADDR;
                        oe_d    = 1'b0;
                    end
                end
                ADDR: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        addr_d      = shift_q;
                        oe_d        = 1'b1;
                        state_d     = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    oe_d    = 1'b0;
                    state_d = DATA;
                end
                DATA: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        wdata_d     = shift_q;
                        we_d        = 1'b1;
                        inc_d       = AUTO_INC;
                        oe_d        = 1'b1;
                        state_d     = DATA_ACK;
                    end
                end
                DATA_ACK: begin
                    oe_d    = 1'b0;
                    state_d = DATA;
                end
                RD_DATA: begin
                    if (byte_done_q) begin
                        byte_done_d = 1'b0;
                        oe_d        = 1'b0;
                        state_d     = RD_ACK;
                    end else begin
                        oe_d    = ~rd_sh_q[6];
                        rd_sh_d = {rd_sh_q[5:0], 1'b0};
                    end
                end
                // a FALL here means the master ACKed (NACK already left for IGNORE)
                RD_ACK: begin
                    rd_sh_d = reg_rdata_i[6:0];
                    oe_d    = ~reg_rdata_i[7];
                    state_d = RD_DATA;
                end
                IGNORE: begin
                    oe_d = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // state and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            byte_done_q <= 1'b0;
            shift_q     <= 8'd0;
            rd_sh_q     <= 7'd0;
            addr_q      <= 8'd0;
            wdata_q     <= 8'd0;
            we_q        <= 1'b0;
            inc_q       <= 1'b0;
            oe_q        <= 1'b0;
            busy_q      <= 1'b0;
            rw_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_done_q <= byte_done_d;
            shift_q     <= shift_d;
            rd_sh_q     <= rd_sh_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            inc_q       <= inc_d;
            oe_q        <= oe_d;
            busy_q      <= busy_d;
            rw_q        <= rw_d;
        end
    end

    assign siod_oe_o   = oe_q;
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = wdata_q;
    assign reg_we_o    = we_q;
    assign busy_o      = busy_q;

endmodule
